// File: rtl/lif_layer_sched.sv
// lif_layer_sched: a layer of N_NEURON leaky integrate-and-fire neurons time-multiplexed onto
// a single update datapath. A frame of signed weighted inputs is accepted in IDLE. PROC then
// updates one neuron per cycle. The resulting spike vector is held in DONE until the consumer
// takes it.
//
// Ports:
//   clk_i          clock, all state changes on the rising edge
//   rst_ni         asynchronous active-low reset
//   in_valid_i     input frame valid
//   in_ready_o     block can accept a frame (IDLE and no clear request)
//   spike_in_i     signed weighted input per neuron, neuron i at [i*V_SIZE +: V_SIZE]
//   clear_i        synchronous request (honoured in IDLE) to zero all stored voltages
//   out_valid_o    spike vector valid
//   out_ready_i    consumer accepts spike vector
//   spike_out_o    bit i set when neuron i spiked this frame
//   busy_o         high whenever the scheduler is not idle
module lif_layer_sched #(
    parameter int unsigned N_NEURON  = 4,
    parameter int unsigned V_SIZE    = 5,
    parameter int unsigned THRESHOLD = 8,
    parameter int unsigned V_LEAK    = 1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [N_NEURON*V_SIZE-1:0]   spike_in_i,
    input  logic                         clear_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [N_NEURON-1:0]          spike_out_o,
    output logic                         busy_o
);

    localparam int unsigned       IdxW    = (N_NEURON > 1) ? $clog2(N_NEURON) : 1;
    localparam int unsigned       VW      = V_SIZE - 1;
    localparam logic [IdxW-1:0]   LastIdx = IdxW'(N_NEURON - 1);
    localparam logic [V_SIZE-1:0] Leak    = V_SIZE'(V_LEAK);
    localparam logic [VW-1:0]     VMax    = '1;

    typedef enum logic [1:0] {StIdle, StProc, StDone} state_e;

    state_e                       state_q, state_d;
    logic [IdxW-1:0]              idx_q, idx_d;
    logic [N_NEURON*V_SIZE-1:0]   in_q, in_d;
    logic [VW-1:0]                v_q [N_NEURON];
    logic [VW-1:0]                v_d [N_NEURON];
    logic [N_NEURON-1:0]          spike_q, spike_d;
    logic                         out_valid_q, out_valid_d;

    logic [V_SIZE-1:0]            in_sel;
    logic [V_SIZE-1:0]            presum;
    logic [V_SIZE-1:0]            sum;
    logic [VW-1:0]                v_sel;
    logic [VW-1:0]                result;
    logic                         fire;

    // Operand select for the neuron under update; the compare loop keeps non-power-of-two
    // neuron counts from indexing past the arrays.
    always_comb begin
        in_sel = '0;
        v_sel  = '0;
        for (int i = 0; i < int'(N_NEURON); i++) begin
            if (idx_q == IdxW'(i)) begin
                in_sel = in_q[i*V_SIZE +: V_SIZE];
                v_sel  = v_q[i];
            end
        end
    end

    // All arithmetic wraps at V_SIZE bits; the sign bits then flag overflow and underflow.
    assign presum = {1'b0, v_sel} + in_sel;
    assign sum    = presum - Leak;

    always_comb begin
        if (!in_sel[V_SIZE-1] && presum[V_SIZE-1]) begin
            // Non-negative input yet negative presum: positive overflow, saturate.
            result = VMax;
        end else if (presum[V_SIZE-1] || sum[V_SIZE-1]) begin
            result = '0;
        end else begin
            result = sum[VW-1:0];
        end
    end

    assign fire = 32'(result) >= THRESHOLD;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        in_d        = in_q;
        v_d         = v_q;
        spike_d     = spike_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            StIdle: begin
                if (clear_i) begin
                    for (int i = 0; i < int'(N_NEURON); i++) begin
                        v_d[i] = '0;
                    end
                end else if (in_valid_i) begin
                    in_d    = spike_in_i;
                    idx_d   = '0;
                    spike_d = '0;
                    state_d = StProc;
                end
            end
            StProc: begin
                for (int i = 0; i < int'(N_NEURON); i++) begin
                    if (idx_q == IdxW'(i)) begin
                        spike_d[i] = fire;
                        v_d[i]     = fire ? '0 : result;
                    end
                end
                if (idx_q == LastIdx) begin
                    idx_d       = '0;
                    out_valid_d = 1'b1;
                    state_d     = StDone;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StDone: begin
                if (out_ready_i) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            in_q        <= '0;
            spike_q     <= '0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < int'(N_NEURON); i++) begin
                v_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            in_q        <= in_d;
            spike_q     <= spike_d;
            out_valid_q <= out_valid_d;
            v_q         <= v_d;
        end
    end

    assign in_ready_o  = (state_q == StIdle) && !clear_i;
    assign busy_o      = (state_q != StIdle);
    assign out_valid_o = out_valid_q;
    assign spike_out_o = spike_q;

endmodule
